// File: rtl/lia_regs_avs.sv
// lia_regs_avs -- Avalon-MM register bank for the lock-in control path.
//
// Holds per-channel NCO phase increment/offset settings behind shadow
// registers, so every channel retunes in the same cycle. The retune happens
// either immediately or aligned to the next lock-in sample. Also holds the
// direct DAC/gain controls, and captures coherent X/Y snapshots of all
// channels together with a 16-bit sample count.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   avs_*                 Avalon-MM slave: 6-bit word address, read latency 1,
//                         waitrequest only for shadow writes during a pending
//                         sample-aligned commit
//   lia_x, lia_y          lock-in results per channel (ch0 in LSBs)
//   lia_valid             one-cycle strobe marking a new coherent sample
//   phase_incr/phase_offs active phase settings (ch0 in LSBs)
//   control_bits, dac_gain, dac_div, gain_ctrl  direct control registers
//   update_pulse          high in the first cycle new phase settings are visible
module lia_regs_avs #(
  parameter int N_CH    = 8,
  parameter int PHASE_W = 20,
  parameter int LIA_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    avs_waitrequest,
  input  logic [N_CH*LIA_W-1:0]   lia_x,
  input  logic [N_CH*LIA_W-1:0]   lia_y,
  input  logic                    lia_valid,
  output logic [N_CH*PHASE_W-1:0] phase_incr,
  output logic [N_CH*PHASE_W-1:0] phase_offs,
  output logic [7:0]              control_bits,
  output logic [7:0]              dac_gain,
  output logic [7:0]              dac_div,
  output logic [5:0]              gain_ctrl,
  output logic                    update_pulse
);

  typedef enum logic [1:0] {
    SNAP_IDLE  = 2'd0,
    SNAP_ARMED = 2'd1,
    SNAP_DONE  = 2'd2
  } snap_t;

  logic [PHASE_W-1:0] shadow_incr [N_CH];
  logic [PHASE_W-1:0] shadow_offs [N_CH];
  logic [PHASE_W-1:0] act_incr    [N_CH];
  logic [PHASE_W-1:0] act_offs    [N_CH];
  logic [LIA_W-1:0]   snap_x      [N_CH];
  logic [LIA_W-1:0]   snap_y      [N_CH];
  logic [15:0]        sample_cnt;
  logic [15:0]        snap_cnt;
  logic               commit_pending;
  snap_t              snap_state;
  snap_t              snap_next;
  logic               snap_capture;

  logic               wr_en;
  logic               commit_wr;
  logic               commit_now;
  logic               snap_wr;
  logic [2:0]         ch_idx;
  logic [31:0]        rd_mux;
  logic [31-PHASE_W:0] unused_wdata;

  assign unused_wdata = avs_writedata[31:PHASE_W];
  assign ch_idx       = avs_address[2:0];

  // Only shadow writes stall, and only while a sample-aligned commit waits;
  // this keeps the committed set from being altered before it is applied.
  assign avs_waitrequest = avs_write && (avs_address[5:4] == 2'b00) && commit_pending;
  assign wr_en           = avs_write && !avs_waitrequest;
  assign commit_wr       = wr_en && (avs_address == 6'h14);
  assign snap_wr         = wr_en && (avs_address == 6'h15);

  // The pending flag is tested before it is set, so a sample-aligned commit
  // written alongside lia_valid waits for the following sample.
  assign commit_now = (commit_wr && !avs_writedata[0]) || (commit_pending && lia_valid);

  // Shadow and direct registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow_incr[i] <= '0;
        shadow_offs[i] <= '0;
      end
      control_bits <= '0;
      dac_gain     <= '0;
      dac_div      <= '0;
      gain_ctrl    <= '0;
    end else if (wr_en) begin
      if (avs_address[5:3] == 3'b000) shadow_incr[ch_idx] <= avs_writedata[PHASE_W-1:0];
      if (avs_address[5:3] == 3'b001) shadow_offs[ch_idx] <= avs_writedata[PHASE_W-1:0];
      case (avs_address)
        6'h10:   control_bits <= avs_writedata[7:0];
        6'h11:   dac_gain     <= avs_writedata[7:0];
        6'h12:   dac_div      <= avs_writedata[7:0];
        6'h13:   gain_ctrl    <= avs_writedata[5:0];
        default: ;
      endcase
    end
  end

  // Commit: shadow -> active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        act_incr[i] <= '0;
        act_offs[i] <= '0;
      end
      commit_pending <= 1'b0;
      update_pulse   <= 1'b0;
    end else begin
      update_pulse <= commit_now;
      if (commit_now) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          act_incr[i] <= shadow_incr[i];
          act_offs[i] <= shadow_offs[i];
        end
        commit_pending <= 1'b0;
      end else if (commit_wr && avs_writedata[0]) begin
        commit_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    phase_incr = '0;
    phase_offs = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      phase_incr[i*PHASE_W +: PHASE_W] = act_incr[i];
      phase_offs[i*PHASE_W +: PHASE_W] = act_offs[i];
    end
  end

  // Snapshot FSM; a SNAP_CTRL write takes priority over a concurrent sample,
  // so the arming cycle itself never captures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) snap_state <= SNAP_IDLE;
    else       snap_state <= snap_next;
  end

  always_comb begin
    snap_next    = snap_state;
    snap_capture = 1'b0;
    if (snap_wr) begin
      if (avs_writedata[0])              snap_next = SNAP_ARMED;
      else if (snap_state == SNAP_ARMED) snap_next = SNAP_IDLE;
    end else if ((snap_state == SNAP_ARMED) && lia_valid) begin
      snap_next    = SNAP_DONE;
      snap_capture = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
      sample_cnt <= '0;
      snap_cnt   <= '0;
    end else begin
      if (lia_valid) sample_cnt <= sample_cnt + 16'd1;
      if (snap_capture) begin
        // Capture only occurs on lia_valid, so the count includes this sample.
        snap_cnt <= sample_cnt + 16'd1;
        for (int unsigned i = 0; i < N_CH; i++) begin
          snap_x[i] <= lia_x[i*LIA_W +: LIA_W];
          snap_y[i] <= lia_y[i*LIA_W +: LIA_W];
        end
      end
    end
  end

  // Read path
  always_comb begin
    rd_mux = '0;
    if (avs_address[5:3] == 3'b000)      rd_mux = 32'(shadow_incr[ch_idx]);
    else if (avs_address[5:3] == 3'b001) rd_mux = 32'(shadow_offs[ch_idx]);
    else if (avs_address[5:3] == 3'b100) rd_mux = 32'(signed'(snap_x[ch_idx]));
    else if (avs_address[5:3] == 3'b101) rd_mux = 32'(signed'(snap_y[ch_idx]));
    else begin
      case (avs_address)
        6'h10:   rd_mux = {24'd0, control_bits};
        6'h11:   rd_mux = {24'd0, dac_gain};
        6'h12:   rd_mux = {24'd0, dac_div};
        6'h13:   rd_mux = {26'd0, gain_ctrl};
        6'h14:   rd_mux = {31'd0, commit_pending};
        6'h15:   rd_mux = {30'd0, (snap_state == SNAP_ARMED), (snap_state == SNAP_DONE)};
        6'h16:   rd_mux = {16'd0, snap_cnt};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read && !avs_write;
      if (avs_read && !avs_write) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_lia_regs_avs.sv
// Testbench for lia_regs_avs: reference model of the register map, reads
// checked through a scoreboard queue, outputs checked every cycle.
module tb_lia_regs_avs;
  localparam int N_CH = 8;
  localparam int PW   = 20;
  localparam int LW   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [5:0]        avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid, avs_waitrequest;
  logic [N_CH*LW-1:0] lia_x, lia_y;
  logic              lia_valid;
  logic [N_CH*PW-1:0] phase_incr, phase_offs;
  logic [7:0]        control_bits, dac_gain, dac_div;
  logic [5:0]        gain_ctrl;
  logic              update_pulse;

  lia_regs_avs #(.N_CH(N_CH), .PHASE_W(PW), .LIA_W(LW)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .lia_x(lia_x), .lia_y(lia_y), .lia_valid(lia_valid),
    .phase_incr(phase_incr), .phase_offs(phase_offs),
    .control_bits(control_bits), .dac_gain(dac_gain), .dac_div(dac_div),
    .gain_ctrl(gain_ctrl), .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Reference model
  logic [19:0] m_si[8], m_so[8], m_ai[8], m_ao[8];
  logic [15:0] m_sx[8], m_sy[8];
  logic [7:0]  m_ctrl, m_gain, m_div;
  logic [5:0]  m_gc;
  logic        m_pend, m_armed, m_done, m_upd;
  logic [15:0] m_cnt, m_scnt;
  logic [N_CH*LW-1:0] cx, cy;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] pack20(input logic [19:0] arr[8]);
    logic [159:0] p;
    for (int i = 0; i < 8; i++) p[i*20 +: 20] = arr[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_si[i] = '0; m_so[i] = '0; m_ai[i] = '0; m_ao[i] = '0;
      m_sx[i] = '0; m_sy[i] = '0;
    end
    m_ctrl = '0; m_gain = '0; m_div = '0; m_gc = '0;
    m_pend = 0; m_armed = 0; m_done = 0; m_upd = 0;
    m_cnt = '0; m_scnt = '0;
  endtask

  function automatic logic [31:0] mread(input logic [5:0] a);
    int ch;
    ch = int'(a) % 8;
    if (a < 6'h08) return {12'd0, m_si[ch]};
    if (a < 6'h10) return {12'd0, m_so[ch]};
    if (a >= 6'h20 && a < 6'h28) return {{16{m_sx[ch][15]}}, m_sx[ch]};
    if (a >= 6'h28 && a < 6'h30) return {{16{m_sy[ch][15]}}, m_sy[ch]};
    case (a)
      6'h10: return {24'd0, m_ctrl};
      6'h11: return {24'd0, m_gain};
      6'h12: return {24'd0, m_div};
      6'h13: return {26'd0, m_gc};
      6'h14: return {31'd0, m_pend};
      6'h15: return {30'd0, m_armed, m_done};
      6'h16: return {16'd0, m_scnt};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, check waitrequest, advance the model at the edge,
  // then check every output.
  task automatic step(input logic rd, input logic wr, input logic [5:0] a,
                      input logic [31:0] wd, input logic lv, output logic wdone);
    logic stall, weff, imm, al, copy;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    lia_valid = lv; lia_x = cx; lia_y = cy;
    stall = wr && (a < 6'h10) && m_pend;
    #3;
    chk("waitrequest", 160'(avs_waitrequest), 160'(stall));
    @(posedge clk);
    weff = wr && !stall;
    if (rd && !wr) exp_q.push_back(mread(a));
    imm  = weff && (a == 6'h14) && !wd[0];
    al   = weff && (a == 6'h14) && wd[0];
    copy = imm || (m_pend && lv);
    if (copy) begin
      m_ai = m_si; m_ao = m_so; m_pend = 0;
    end else if (al) m_pend = 1;
    m_upd = copy;
    if (weff) begin
      if (a < 6'h08) m_si[int'(a)] = wd[19:0];
      else if (a < 6'h10) m_so[int'(a) - 8] = wd[19:0];
      else if (a == 6'h10) m_ctrl = wd[7:0];
      else if (a == 6'h11) m_gain = wd[7:0];
      else if (a == 6'h12) m_div = wd[7:0];
      else if (a == 6'h13) m_gc = wd[5:0];
    end
    if (weff && a == 6'h15) begin
      if (wd[0]) begin m_armed = 1; m_done = 0; end
      else if (m_armed) m_armed = 0;
    end else if (m_armed && lv) begin
      for (int i = 0; i < 8; i++) begin
        m_sx[i] = cx[i*16 +: 16]; m_sy[i] = cy[i*16 +: 16];
      end
      m_scnt = m_cnt + 16'd1;
      m_armed = 0; m_done = 1;
    end
    if (lv) m_cnt = m_cnt + 16'd1;
    wdone = weff;
    #1;
    chk("phase_incr", 160'(phase_incr), pack20(m_ai));
    chk("phase_offs", 160'(phase_offs), pack20(m_ao));
    chk("ctrl_regs", 160'({control_bits, dac_gain, dac_div, gain_ctrl}), 160'({m_ctrl, m_gain, m_div, m_gc}));
    chk("update_pulse", 160'(update_pulse), 160'(m_upd));
    avs_read = 0; avs_write = 0; lia_valid = 0;
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) step(0, 0, 6'h00, 32'd0, 0, d);
  endtask

  task automatic rd_reg(input logic [5:0] a);
    logic d;
    step(1, 0, a, 32'd0, 0, d);
  endtask

  // Holds the write until it completes; samples keep arriving while stalled.
  task automatic wr_reg(input logic [5:0] a, input logic [31:0] wd, input logic lv0, input logic rd_too);
    logic d, lv;
    d = 0;
    for (int k = 0; k < 20 && !d; k++) begin
      lv = (k == 0) ? lv0 : ((k >= 6) ? 1'b1 : ($urandom_range(0, 3) == 0));
      step(rd_too, 1, a, wd, lv, d);
    end
    if (!d) begin
      miscompares++;
      $display("FAIL write_timeout: addr %0h not accepted, required within 20 cycles", a);
    end
  endtask

  task automatic do_reset();
    idle(1);
    reset = 1;
    model_reset();
    #2;
    chk("rst_phase_incr", 160'(phase_incr), 160'd0);
    chk("rst_rdv", 160'(avs_readdatavalid), 160'd0);
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete();
  endtask

  // Read-response monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && avs_readdatavalid) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_read: got %0h, required no response", avs_readdata);
        end else begin
          e = exp_q.pop_front();
          chk("readdata", 160'(avs_readdata), 160'(e));
        end
      end
    end
  end

  initial begin
    logic d;
    logic [5:0] addrs[16];
    addrs = '{6'h00, 6'h03, 6'h07, 6'h08, 6'h0D, 6'h10, 6'h11, 6'h12,
              6'h13, 6'h14, 6'h15, 6'h16, 6'h22, 6'h2F, 6'h18, 6'h3F};
    reset = 1; avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0;
    lia_valid = 0; cx = '0; cy = '0; lia_x = '0; lia_y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_update", 160'(update_pulse), 160'd0);
    rd_reg(6'h15); rd_reg(6'h16); rd_reg(6'h14); rd_reg(6'h00); rd_reg(6'h20);

    // Immediate commit of INCR ch3
    wr_reg(6'h03, 32'h0001_2345, 0, 0);
    wr_reg(6'h14, 32'd0, 0, 0);
    chk("t2_ch3", 160'(phase_incr[79:60]), 160'h12345);
    chk("t2_ch2", 160'(phase_incr[59:40]), 160'd0);
    chk("t2_pulse", 160'(update_pulse), 160'd1);
    idle(1);
    chk("t2_pulse_end", 160'(update_pulse), 160'd0);

    // Sample-aligned commit, sample arrives 10 cycles later
    wr_reg(6'h01, 32'h000A_AAAA, 0, 0);
    wr_reg(6'h09, 32'h0005_5555, 0, 0);
    wr_reg(6'h14, 32'd1, 0, 0);
    rd_reg(6'h14);
    idle(9);
    step(0, 0, 6'h00, 32'd0, 1, d);
    chk("t3_ch1", 160'(phase_incr[39:20]), 160'hAAAAA);
    rd_reg(6'h14);

    // Shadow write stalls behind a pending commit
    wr_reg(6'h14, 32'd1, 0, 0);
    wr_reg(6'h00, 32'h0007_7777, 0, 0);
    chk("t4_ch0_active", 160'(phase_incr[19:0]), 160'd0);
    rd_reg(6'h00);
    wr_reg(6'h14, 32'd0, 0, 0);

    // Snapshot capture and hold
    wr_reg(6'h15, 32'd1, 0, 0);
    cx[95:80] = 16'h8001; cy[15:0] = 16'h1234;
    step(0, 0, 6'h00, 32'd0, 1, d);
    rd_reg(6'h25); rd_reg(6'h15); rd_reg(6'h28); rd_reg(6'h16);
    cx[95:80] = 16'h0042;
    step(0, 0, 6'h00, 32'd0, 1, d);
    rd_reg(6'h25);

    // Arm alongside a sample: capture waits for the next one
    cx[95:80] = 16'h1111;
    wr_reg(6'h15, 32'd1, 1, 0);
    rd_reg(6'h15);
    cx[95:80] = 16'hF222;
    step(0, 0, 6'h00, 32'd0, 1, d);
    rd_reg(6'h25);
    wr_reg(6'h15, 32'd1, 0, 0);
    wr_reg(6'h14, 32'd1, 0, 0);
    rd_reg(6'h15);
    do_reset();
    rd_reg(6'h15); rd_reg(6'h14); rd_reg(6'h25);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] a;
      logic [31:0] wd;
      int kind;
      a = addrs[$urandom_range(0, 15)];
      wd = $urandom();
      if (a == 6'h14 || a == 6'h15) wd[0] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N_CH*LW; i += 32) begin
          cx[i +: 32] = $urandom(); cy[i +: 32] = $urandom();
        end
      end
      kind = $urandom_range(0, 9);
      if (kind < 4) step(1, 0, a, 32'd0, ($urandom_range(0, 4) == 0), d);
      else if (kind < 8) wr_reg(a, wd, ($urandom_range(0, 4) == 0), 0);
      else if (kind == 8) wr_reg(a, wd, ($urandom_range(0, 4) == 0), 1);
      else step(0, 0, 6'h00, 32'd0, ($urandom_range(0, 2) == 0), d);
    end

    // Sample counter wrap
    do_reset();
    for (int n = 0; n < 65537; n++) step(0, 0, 6'h00, 32'd0, 1, d);
    wr_reg(6'h15, 32'd1, 0, 0);
    step(0, 0, 6'h00, 32'd0, 1, d);
    rd_reg(6'h16); rd_reg(6'h15);

    idle(3);
    chk("read_queue_drained", 160'(exp_q.size()), 160'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
